// File: rtl/reg_dump_reader.sv
// Sweeps the register-file read select over R0..NUM_REGS-1 and streams each word out on a valid/ready port.
// Optional build macro DUMP_CHECKSUM_EN appends a running-XOR checksum word after the last register.
module reg_dump_reader #(
    parameter int NUM_REGS = 8,
    parameter int DATA_W   = 16,
    parameter int SEL_W    = 3
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    output logic [SEL_W-1:0]  Rd_Sel,
    input  logic [DATA_W-1:0] Rd_Data,
    output logic [DATA_W-1:0] Out_Data,
    output logic [SEL_W-1:0]  Out_Idx,
    output logic              Out_Chk,
    output logic              Out_Last,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic              Busy,
    output logic              Done
);

    typedef enum logic [1:0] {IDLE, SELECT, PRESENT, CHKSUM} state_t;

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_REGS - 1);

    state_t           state;
    logic [SEL_W-1:0] idx;

`ifdef DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] chk_acc;
`else
    assign Out_Chk = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            idx       <= '0;
            Rd_Sel    <= '0;
            Out_Data  <= '0;
            Out_Idx   <= '0;
            Out_Last  <= 1'b0;
            Out_Valid <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            Out_Chk   <= 1'b0;
            chk_acc   <= '0;
`endif
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        state  <= SELECT;
                        idx    <= '0;
                        Rd_Sel <= '0;
                        Busy   <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
                        chk_acc <= '0;
`endif
                    end
                end
                // Rd_Sel has been stable for the whole cycle; capture the read data now.
                SELECT: begin
                    Out_Data  <= Rd_Data;
                    Out_Idx   <= idx;
                    Out_Valid <= 1'b1;
                    state     <= PRESENT;
`ifdef DUMP_CHECKSUM_EN
                    Out_Last  <= 1'b0;
                    chk_acc   <= chk_acc ^ Rd_Data;
`else
                    Out_Last  <= (idx == LAST_IDX);
`endif
                end
                PRESENT: begin
                    if (Out_Ready) begin
                        Out_Valid <= 1'b0;
                        if (idx == LAST_IDX) begin
`ifdef DUMP_CHECKSUM_EN
                            // chk_acc already folds in the last register word.
                            state     <= CHKSUM;
                            Out_Data  <= chk_acc;
                            Out_Idx   <= '0;
                            Out_Chk   <= 1'b1;
                            Out_Last  <= 1'b1;
                            Out_Valid <= 1'b1;
`else
                            state     <= IDLE;
                            Out_Last  <= 1'b0;
                            Busy      <= 1'b0;
                            Done      <= 1'b1;
`endif
                        end else begin
                            idx    <= idx + 1'b1;
                            Rd_Sel <= idx + 1'b1;
                            state  <= SELECT;
                        end
                    end
                end
                CHKSUM: begin
                    if (Out_Ready) begin
                        Out_Valid <= 1'b0;
                        Out_Last  <= 1'b0;
                        Busy      <= 1'b0;
                        Done      <= 1'b1;
                        state     <= IDLE;
`ifdef DUMP_CHECKSUM_EN
                        Out_Chk   <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
